segment_display_decoder: RTL
============================

// Module: segment_display_decoder
// PURPOSE
//   Receiving end of the multiplexed 4-digit 7-segment bus driven by SegmentDisplay.
//   Samples the enable and segment lines, waits for each digit slot to settle, then
//   decodes the lit pattern back into its 5-bit value {dp, hex}.
//   Rebuilds the Values[0:3] array and marks completed scan frames.
//   Used as a self-check monitor in benches and as a loopback checker on hardware.
// PARAMETERS
//   STABLE_CYCLES   2     consecutive identical samples before a slot is accepted (>=1)
//   TIMEOUT_CYCLES  1024  cycles without an accepted capture before data is declared stale
// PORTS
//   Clk           in   1      system clock, all logic on rising edge
//   Reset         in   1      asynchronous, active-high; clears all state
//   EnableIns     in   4      digit enables, active-high, bit i = digit i
//   SegIns        in   8      segments, active-high: [0]a [1]b [2]c [3]d [4]e [5]f [6]g [7]dp
//   Values        out  5x4    decoded digits [0:3]; bit4 = dp, [3:0] = hex value
//   DigitValid    out  4      digit i holds a valid decode since the last blank or timeout
//   FrameStrobe   out  1      1-cycle pulse when all four digits have been captured
//   PatternError  out  1      1-cycle pulse: settled seg[6:0] is neither a hex glyph nor blank
//   MuxError      out  1      1-cycle pulse: settled EnableIns has more than one bit set
//   Stale         out  1      high after a timeout, until the next accepted capture
// BEHAVIOUR
//   - Reset values: Values = 0, DigitValid = 0, FrameStrobe = 0, PatternError = 0,
//     MuxError = 0, Stale = 1. Internal state: stable_cnt = 0, captured = 0, seen = 0,
//     tmo_cnt = 0.
//   - Inputs are registered once into a sample register {en_q, seg_q}.
//   - stable_cnt: 0 when {en_q, seg_q} differs from the previous sample, otherwise
//     increments, saturating at STABLE_CYCLES-1. Any change also clears captured.
//   - Accept: stable_cnt == STABLE_CYCLES-1 and !captured. This sets captured, so each
//     settled slot is acted on exactly once.
//     Latency from pin change to output update = STABLE_CYCLES+1 cycles.
//   - Actions on accept:
//     - en_q one-hot (digit d), seg_q[6:0] is a hex glyph:
//       Values[d] <= {seg_q[7], nibble}; DigitValid[d] <= 1; seen[d] <= 1;
//       Stale <= 0; tmo_cnt <= 0.
//     - en_q one-hot, seg_q[6:0] == 0 (blank): DigitValid[d] <= 0; Values[d] unchanged;
//       seen[d] <= 1; timeout is reset.
//     - en_q one-hot, unknown glyph: PatternError pulse; Values[d], DigitValid[d] and
//       seen[d] unchanged.
//     - en_q == 0: no action (inter-digit gap).
//     - en_q has >1 bit set: MuxError pulse; no other effect.
//   - Glyph table, index = gfedcba:
//     - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7
//     - 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F
//   - Frame: when the next value of seen is 4'b1111, FrameStrobe pulses on that edge and
//     seen returns to 0. The completing digit is already visible in Values when the
//     strobe is high. Digits are accepted in any order; repeats of a digit are harmless.
//   - Timeout: tmo_cnt increments each cycle without an accepted capture (saturating).
//     When it reaches TIMEOUT_CYCLES-1: DigitValid <= 0, seen <= 0, Stale <= 1.
//     Values are kept. If a capture and a timeout fall on the same edge, the capture wins.
//   - Reset asserted mid-frame clears everything immediately.
//     After release, the first settled slot needs the full STABLE_CYCLES+1 latency.
// STRUCTURE
//   - Package segdec_pkg:
//     - segment bit index constants (SEG_A..SEG_G, SEG_DP), SEG_BLANK = 7'h00;
//     - typedef digit_t = logic [4:0];
//     - function glyph_to_hex(input [6:0]) returning {valid, nibble}.
//   - Sub-module seg7_to_hex: combinational; seg[6:0] in; nibble, is_hex and is_blank out.
//     Instantiated once on seg_q. Everything else stays in the top module.
// TESTING
//   1. Hold EnableIns=0001, SegIns=8'h3F for 4 cycles.
//      -> Values[0]=5'h00, DigitValid=0001 exactly 3 cycles after the change;
//      no FrameStrobe.
//   2. Scan digits 0..3 with patterns 06, 5B, 4F, 66 plus dp set (bit7), 8 cycles each.
//      -> Values = 11,12,13,14 (hex); single FrameStrobe on the digit-3 capture edge.
//   3. Slot 2 glitches: 1 cycle of 8'h7F, then 8'h3F.
//      -> only 0 is captured into Values[2]; the glitch never appears.
//   4. Slot pattern 8'h49 on digit 1 -> one PatternError pulse; Values[1]/DigitValid[1] kept.
//      EnableIns=0011, SegIns=8'h3F -> one MuxError pulse; no Values change.
//   5. Valid frame, then EnableIns=0 for TIMEOUT_CYCLES.
//      -> DigitValid=0, Stale=1, Values kept.
//      Next valid capture clears Stale the same cycle Values updates.
//   6. Assert Reset for 1 cycle after 2 of 4 digits are captured.
//      -> all outputs return to reset values;
//      a full new scan is needed before FrameStrobe pulses.

Source files
------------

// File: rtl/segdec_pkg.sv
// Shared definitions for the 7-segment bus decoder: segment bit positions,
// the decoded digit type and the glyph lookup.
package segdec_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // {dp, hex nibble}
  typedef logic [4:0] digit_t;

  // Returns {valid, nibble}; index is gfedcba.
  function automatic logic [4:0] glyph_to_hex(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational glyph classifier: hex nibble, hex-glyph flag and blank flag.
module seg7_to_hex
  import segdec_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       is_hex,
  output logic       is_blank
);

  assign {is_hex, nibble} = glyph_to_hex(seg);
  assign is_blank         = (seg == SEG_BLANK);

endmodule

// File: rtl/segment_display_decoder.sv
// Monitor for a multiplexed 4-digit 7-segment bus: waits for each digit slot to
// settle, decodes it back to {dp, hex}, and tracks frame completion and staleness.
module segment_display_decoder
  import segdec_pkg::*;
#(
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] EnableIns,
  input  logic [7:0] SegIns,
  output digit_t     Values [0:3],
  output logic [3:0] DigitValid,
  output logic       FrameStrobe,
  output logic       PatternError,
  output logic       MuxError,
  output logic       Stale
);

  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0]    en_q;
  logic [7:0]    seg_q;
  logic [SW-1:0] stable_cnt;
  logic          captured;
  logic [3:0]    seen;
  logic [TW-1:0] tmo_cnt;

  logic [3:0] nibble;
  logic       is_hex, is_blank;

  seg7_to_hex u_glyph (
    .seg      (seg_q[6:0]),
    .nibble   (nibble),
    .is_hex   (is_hex),
    .is_blank (is_blank)
  );

  logic       changed, accept, one_hot, multi;
  logic       cap_hex, cap_blank, cap, tmo_hit;
  logic [3:0] seen_nxt;

  always_comb begin
    changed   = ({EnableIns, SegIns} != {en_q, seg_q});
    accept    = (stable_cnt == STABLE_MAX) && !captured;
    one_hot   = (en_q != 4'b0) && ((en_q & (en_q - 4'd1)) == 4'b0);
    multi     = (en_q != 4'b0) && !one_hot;
    cap_hex   = accept && one_hot && is_hex;
    cap_blank = accept && one_hot && is_blank;
    cap       = cap_hex || cap_blank;
    seen_nxt  = seen | en_q;
    tmo_hit   = (tmo_cnt == TMO_MAX);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      en_q         <= '0;
      seg_q        <= '0;
      stable_cnt   <= '0;
      captured     <= 1'b0;
      seen         <= '0;
      tmo_cnt      <= '0;
      for (int i = 0; i < 4; i++) Values[i] <= '0;
      DigitValid   <= '0;
      FrameStrobe  <= 1'b0;
      PatternError <= 1'b0;
      MuxError     <= 1'b0;
      Stale        <= 1'b1;
    end else begin
      en_q  <= EnableIns;
      seg_q <= SegIns;

      // A change restarts settling; the accept below still acts on the old sample.
      if (changed) begin
        stable_cnt <= '0;
        captured   <= 1'b0;
      end else begin
        if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + 1'b1;
        if (accept) captured <= 1'b1;
      end

      FrameStrobe  <= 1'b0;
      PatternError <= accept && one_hot && !is_hex && !is_blank;
      MuxError     <= accept && multi;

      for (int i = 0; i < 4; i++) begin
        if (cap_hex && en_q[i]) begin
          Values[i]     <= {seg_q[SEG_DP], nibble};
          DigitValid[i] <= 1'b1;
        end
        if (cap_blank && en_q[i]) DigitValid[i] <= 1'b0;
      end

      // Capture takes priority over a timeout on the same edge.
      if (cap) begin
        tmo_cnt <= '0;
        if (cap_hex) Stale <= 1'b0;
        if (seen_nxt == 4'hF) begin
          FrameStrobe <= 1'b1;
          seen        <= '0;
        end else begin
          seen <= seen_nxt;
        end
      end else if (tmo_hit) begin
        DigitValid <= '0;
        seen       <= '0;
        Stale      <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule
